// File: rtl/fft_pair_feeder.sv
// Radix-2 DIT FFT input stage: fills one frame at bit-reversed addresses, then
// drains it as first-stage butterfly operand pairs (mem[2k], mem[2k+1]).
module fft_pair_feeder #(
    parameter int WIDTH = 16,
    parameter int N     = 8,
    parameter int LOGN  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_r,
    input  logic [WIDTH-1:0]  in_i,
    output logic              pair_valid,
    input  logic              pair_ready,
    output logic [WIDTH-1:0]  in1_r,
    output logic [WIDTH-1:0]  in1_i,
    output logic [WIDTH-1:0]  in2_r,
    output logic [WIDTH-1:0]  in2_i,
    output logic [LOGN-2:0]   pair_idx,
    output logic              frame_done,
    output logic              dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid && ready;
    // valid never depends on ready, and a presented pair holds until it transfers.

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [LOGN-1:0]   wr_cnt_q, wr_cnt_d;
    logic [LOGN-2:0]   rd_cnt_q, rd_cnt_d;
    logic              done_q, done_d;
    logic              wr_en;

    logic [2*WIDTH-1:0] mem [N];
    logic [2*WIDTH-1:0] rd0, rd1;
    logic [LOGN-1:0]    rd_addr0, rd_addr1;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
        logic [LOGN-1:0] r;
        for (int b = 0; b < LOGN; b++) begin
            r[b] = a[LOGN-1-b];
        end
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        done_d     = 1'b0;
        in_ready   = 1'b0;
        pair_valid = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            FILL: begin
                in_ready = rst_n;
                if (in_valid && in_ready) begin
                    wr_en = 1'b1;
                    if (wr_cnt_q == LOGN'(N - 1)) begin
                        state_d  = DRAIN;
                        wr_cnt_d = '0;
                    end else begin
                        wr_cnt_d = wr_cnt_q + LOGN'(1);
                    end
                end
            end
            DRAIN: begin
                pair_valid = rst_n;
                if (pair_valid && pair_ready) begin
                    if (rd_cnt_q == (LOGN-1)'(N/2 - 1)) begin
                        state_d  = FILL;
                        rd_cnt_d = '0;
                        done_d   = 1'b1;
                    end else begin
                        rd_cnt_d = rd_cnt_q + (LOGN-1)'(1);
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= FILL;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            done_q   <= done_d;
        end
    end

    // Buffer is deliberately not reset; a new frame always overwrites every slot.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[bitrev(wr_cnt_q)] <= {in_r, in_i};
        end
    end

    assign rd_addr0 = {rd_cnt_q, 1'b0};
    assign rd_addr1 = {rd_cnt_q, 1'b1};
    assign rd0      = mem[rd_addr0];
    assign rd1      = mem[rd_addr1];

    always_comb begin
        in1_r    = '0;
        in1_i    = '0;
        in2_r    = '0;
        in2_i    = '0;
        pair_idx = '0;
        if (pair_valid) begin
            in1_r    = rd0[2*WIDTH-1:WIDTH];
            in1_i    = rd0[WIDTH-1:0];
            in2_r    = rd1[2*WIDTH-1:WIDTH];
            in2_i    = rd1[WIDTH-1:0];
            pair_idx = rd_cnt_q;
        end
    end

    assign frame_done = done_q & rst_n;
    assign dbg_state  = state_q;

endmodule
